// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with per-packet route lock.
// Optional per-branch handshake counters are enabled with `define DEMUX_CNT_EN.
module demux1to2_stream #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic          in_sel,
  output logic          in_ready,
  output logic [DW-1:0] out0_data,
  output logic          out0_valid,
  output logic          out0_last,
  input  logic          out0_ready,
  output logic [DW-1:0] out1_data,
  output logic          out1_valid,
  output logic          out1_last,
  input  logic          out1_ready,
`ifdef DEMUX_CNT_EN
  input  logic          cnt_clr,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
`endif
  output logic          busy,
  output logic          cur_sel
);

  typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} state_t;

  state_t state;
  logic   target;
  logic   free0, free1;
  logic   xfer, load0, load1;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    target = 1'b0;
    unique case (state)
      IDLE:    target = in_sel;
      ROUTE0:  target = 1'b0;
      ROUTE1:  target = 1'b1;
      default: target = 1'b0;
    endcase
  end

  // A branch register can take a beat when empty or when it drains this edge.
  assign free0    = ~out0_valid | out0_ready;
  assign free1    = ~out1_valid | out1_ready;
  assign in_ready = target ? free1 : free0;
  assign xfer     = in_valid & in_ready;
  assign load0    = xfer & ~target;
  assign load1    = xfer &  target;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cur_sel <= 1'b0;
    end else if (xfer) begin
      if (in_last) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state == IDLE) begin
        state   <= in_sel ? ROUTE1 : ROUTE0;
        cur_sel <= in_sel;
        busy    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
      out0_last  <= 1'b0;
    end else if (load0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
      out0_last  <= in_last;
    end else if (out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out1_last  <= 1'b0;
    end else if (load1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
      out1_last  <= in_last;
    end else if (out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  // Counters track completed output handshakes; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready) cnt0 <= cnt0 + 1'b1;
      if (out1_valid && out1_ready) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// Self-checking bench for demux1to2_stream: vector table plus scoreboard queues
// per branch, with hand-written sequences for stall, back-to-back and reset.
module tb_demux1to2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_sel;
  logic       in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out0_last, out0_ready;
  logic       out1_valid, out1_last, out1_ready;
  logic       busy, cur_sel;
`ifdef DEMUX_CNT_EN
  logic        cnt_clr;
  logic [15:0] cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  demux1to2_stream #(.DW(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_sel(in_sel),
    .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last),
    .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last),
    .out1_ready(out1_ready),
`ifdef DEMUX_CNT_EN
    .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1),
`endif
    .busy(busy), .cur_sel(cur_sel)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a completed output handshake pops the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) check("out0_unexpected_beat", {23'd0, out0_last, out0_data}, 32'h1ff);
        else check("out0_beat", {23'd0, out0_last, out0_data}, {23'd0, q0.pop_front()});
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("out1_unexpected_beat", {23'd0, out1_last, out1_data}, 32'h1ff);
        else check("out1_beat", {23'd0, out1_last, out1_data}, {23'd0, q1.pop_front()});
      end
    end
  end

  // Present one beat, wait (bounded) for acceptance, push the expected result.
  task automatic send(input logic [7:0] d, input logic l, input logic s,
                      input logic br, output int waits);
    in_data  = d;
    in_last  = l;
    in_sel   = s;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    else if (br) q1.push_back({l, d});
    else q0.push_back({l, d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic       last;
    logic       exp_br;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[8];
  int   w;

  initial begin
    // Single beat, 3-beat packet with in_sel toggled mid-packet, then mixed traffic.
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h7E, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h81, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
`ifdef DEMUX_CNT_EN
    cnt_clr = 1'b0;
`endif
    tick(3);
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_sel", cur_sel, 0);
    check("rst_out0_data", {out0_last, out0_data}, 0);
    check("rst_out1_data", {out1_last, out1_data}, 0);
    rst_n = 1'b1;
    tick(1);
    check("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data, vecs[i].last, vecs[i].sel, vecs[i].exp_br, w);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      if (i == 0) begin
        check("single_out1_valid", out1_valid, 1);
        check("single_out1_data", out1_data, 8'hA5);
        check("single_out0_valid", out0_valid, 0);
      end
      if (i == 1) check("pkt_cur_sel", cur_sel, 0);
    end
    tick(2);

    // Stall: out0 holds a beat, out1 holds a beat; only out1 releases.
    out0_ready = 1'b0; out1_ready = 1'b0;
    send(8'h44, 1'b1, 1'b1, 1'b1, w);
    send(8'h55, 1'b1, 1'b0, 1'b0, w);
    in_data = 8'h66; in_last = 1'b1; in_sel = 1'b0; in_valid = 1'b1;
    out1_ready = 1'b1;
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_out0_data", out0_data, 8'h55);
    tick(1);
    @(negedge clk);
    check("stall_out1_drained", out1_valid, 0);
    check("stall_in_ready2", in_ready, 0);
    check("stall_out0_held", {out0_valid, out0_data}, 9'h155);
    @(posedge clk); #1;
    out0_ready = 1'b1;
    send(8'h66, 1'b1, 1'b0, 1'b0, w);
    tick(2);

    // Back-to-back 4-beat packet to out1: accepted without any wait cycle.
    for (int i = 0; i < 4; i++) begin
      send(8'hC0 + 8'(i), (i == 3), (i == 0), 1'b1, w);
      check($sformatf("b2b_wait%0d", i), w, 0);
      check($sformatf("b2b_out1_valid%0d", i), out1_valid, 1);
    end
    tick(2);

    // Reset after beat 2 of a 4-beat packet to out1.
    send(8'hD0, 1'b0, 1'b1, 1'b1, w);
    send(8'hD1, 1'b0, 1'b0, 1'b1, w);
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    check("midrst_valids", {out0_valid, out1_valid}, 0);
    check("midrst_busy", busy, 0);
    tick(1);
    rst_n = 1'b1;
    send(8'hE0, 1'b0, 1'b0, 1'b0, w);
    check("post_rst_route", {out0_valid, cur_sel}, 2'b10);
    send(8'hE1, 1'b1, 1'b1, 1'b0, w);
    tick(2);

`ifdef DEMUX_CNT_EN
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(i), 1'b1, 1'b0, 1'b0, w);
    for (int i = 0; i < 2; i++) send(8'(8'h40 + i), 1'b1, 1'b1, 1'b1, w);
    tick(3);
    check("cnt0", cnt0, 5);
    check("cnt1", cnt1, 2);
    send(8'h99, 1'b1, 1'b0, 1'b0, w);
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    check("cnt_clr", {cnt0, cnt1}, 0);
`endif

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) tick(1);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
